// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: I-cache lookup, static branch prediction and a
// DEPTH-entry fetch queue feeding decode, with miss-safe redirect handling.
module ifu_fetch_queue #(
  parameter logic [31:0] RESET_PC     = 32'h80000000,
  parameter int unsigned DEPTH        = 4,
  parameter bit          BP_EN        = 1'b1,
  parameter bit          STALL_ON_SYS = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [31:0]                  ic_addr,
  input  logic                         ic_hit,
  input  logic [31:0]                  ic_inst,
  input  logic                         jump_flush,
  input  logic [31:0]                  jump_dnpc,
  input  logic                         cs_flush,
  input  logic [31:0]                  cs_dnpc,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_inst,
  output logic                         out_pred_taken,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic          r_pred_mem [DEPTH];

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_pc;
  logic          r_redir_pend;
  logic [31:0]   r_dnpc;
  logic          r_sys_stall;

  logic          w_flush;
  logic [31:0]   w_dnpc;
  logic          w_full;
  logic          w_empty;
  logic          w_enq;
  logic          w_deq;
  logic [31:0]   w_imm_b;
  logic [31:0]   w_imm_j;
  logic          w_is_br;
  logic          w_is_jal;
  logic          w_is_sys;
  logic [31:0]   w_incr;
  logic          w_pred_taken;
  logic [31:0]   w_next;
  logic          w_sys_hold;
  logic [CW-1:0] w_count_nxt;

  assign w_flush = jump_flush | cs_flush;
  assign w_dnpc  = cs_flush ? cs_dnpc : jump_dnpc;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign out_valid = ~w_empty & ~w_flush;
  assign w_deq     = out_valid & out_ready;
  assign w_enq     = ic_hit & ~w_flush & ~r_redir_pend & ~r_sys_stall & (~w_full | w_deq);

  assign w_imm_b  = {{20{ic_inst[31]}}, ic_inst[7], ic_inst[30:25], ic_inst[11:8], 1'b0};
  assign w_imm_j  = {{12{ic_inst[31]}}, ic_inst[19:12], ic_inst[20], ic_inst[30:21], 1'b0};
  assign w_is_br  = (ic_inst[6:0] == 7'b1100011);
  assign w_is_jal = (ic_inst[6:0] == 7'b1101111);
  assign w_is_sys = (ic_inst[6:2] == 5'b11100);

  always_comb begin
    w_incr = 32'd4;
    if (BP_EN) begin
      if (w_is_br && ic_inst[31]) begin
        w_incr = w_imm_b;
      end else if (w_is_jal) begin
        w_incr = w_imm_j;
      end
    end
  end

  assign w_pred_taken = (w_incr != 32'd4);
  assign w_next       = r_fetch_pc + w_incr;
  // A stalling SYS instruction leaves fetch_pc parked on itself.
  assign w_sys_hold   = STALL_ON_SYS & w_is_sys;

  assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_enq} - {{(CW-1){1'b0}}, w_deq};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_dnpc       <= '0;
      r_sys_stall  <= 1'b0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else begin
      // fetch_pc only moves on a hit so a refill in progress sees a stable address.
      if (ic_hit) begin
        if (w_flush) begin
          r_fetch_pc   <= w_dnpc;
          r_redir_pend <= 1'b0;
        end else if (r_redir_pend) begin
          r_fetch_pc   <= r_dnpc;
          r_redir_pend <= 1'b0;
        end else if (w_enq && !w_sys_hold) begin
          r_fetch_pc <= w_next;
        end
      end else if (w_flush) begin
        r_redir_pend <= 1'b1;
        r_dnpc       <= w_dnpc;
      end

      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= w_count_nxt;
      end

      if (w_flush) begin
        r_sys_stall <= 1'b0;
      end else if (w_enq && w_sys_hold) begin
        r_sys_stall <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_inst_mem[r_wr_ptr] <= ic_inst;
      r_pred_mem[r_wr_ptr] <= w_pred_taken;
    end
  end

  assign ic_addr        = r_fetch_pc;
  assign out_pc         = r_pc_mem[r_rd_ptr];
  assign out_inst       = r_inst_mem[r_rd_ptr];
  assign out_pred_taken = r_pred_mem[r_rd_ptr];
  assign q_count        = r_count;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue; a second instance with BP_EN=0 shares
// all stimulus so the two prediction modes can be compared side by side.
module tb_ifu_fetch_queue;

  logic        clock;
  logic        reset;
  logic        ic_hit;
  logic        jump_flush;
  logic [31:0] jump_dnpc;
  logic        cs_flush;
  logic [31:0] cs_dnpc;
  logic        out_ready;
  int          mode;

  logic [31:0] ic_addr,  ic_inst;
  logic        out_valid, out_pred_taken;
  logic [31:0] out_pc, out_inst;
  logic [2:0]  q_count;

  logic [31:0] nb_ic_addr, nb_ic_inst;
  logic        nb_out_valid, nb_out_pred_taken;
  logic [31:0] nb_out_pc, nb_out_inst;
  logic [2:0]  nb_q_count;

  int checks = 0;
  int errors = 0;
  int emitted;

  // Program image: NOPs everywhere except the instruction under test.
  function automatic logic [31:0] inst_at(input logic [31:0] a, input int m);
    if (m == 1 && a == 32'h80000008) return 32'hFE000CE3;
    if (m == 2 && a == 32'h80000004) return 32'h00000073;
    return 32'h00000013;
  endfunction

  always_comb ic_inst    = inst_at(ic_addr, mode);
  always_comb nb_ic_inst = inst_at(nb_ic_addr, mode);

  ifu_fetch_queue #(.BP_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_inst(ic_inst),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc), .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_pred_taken(out_pred_taken), .q_count(q_count)
  );

  ifu_fetch_queue #(.BP_EN(1'b0)) dut_nbp (
    .clock(clock), .reset(reset), .ic_addr(nb_ic_addr), .ic_hit(ic_hit), .ic_inst(nb_ic_inst),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc), .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .out_ready(out_ready), .out_valid(nb_out_valid), .out_pc(nb_out_pc),
    .out_inst(nb_out_inst), .out_pred_taken(nb_out_pred_taken), .q_count(nb_q_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    jump_flush = 1'b0;
    cs_flush   = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ic_hit = 1'b1; mode = 0; out_ready = 1'b1;
    jump_flush = 1'b0; jump_dnpc = '0; cs_flush = 1'b0; cs_dnpc = '0;

    // Reset state and streaming NOPs.
    reset = 1'b1;
    step();
    step();
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", ic_addr, 32'h80000000);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc", out_pc, 32'h80000000 + 32'(4 * k));
      check("stream_pred", 32'(out_pred_taken), 32'd0);
    end

    // Back-pressure: queue fills then drains in order, full+deq keeps count.
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) step();
    check("full_count", 32'(q_count), 32'd4);
    check("full_addr", ic_addr, 32'h80000010);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_pc", out_pc, 32'h80000000 + 32'(4 * k));
      step();
      check("drain_count", 32'(q_count), 32'd4);
    end

    // Backward BEQ at 0x80000008.
    mode = 1;
    do_reset();
    step();
    step();
    step();
    check("beq_pc", out_pc, 32'h80000008);
    check("beq_pred_bp", 32'(out_pred_taken), 32'd1);
    check("beq_pred_nbp", 32'(nb_out_pred_taken), 32'd0);
    step();
    check("beq_next_bp", out_pc, 32'h80000000);
    check("beq_next_nbp", nb_out_pc, 32'h8000000C);
    check("beq_next_pred_nbp", 32'(nb_out_pred_taken), 32'd0);

    // Redirect during a cache miss.
    mode = 0;
    out_ready = 1'b0;
    do_reset();
    step();
    ic_hit = 1'b0;
    step();
    check("miss_valid_pre", 32'(out_valid), 32'd1);
    jump_flush = 1'b1;
    jump_dnpc  = 32'h80001000;
    #1;
    check("miss_flush_valid", 32'(out_valid), 32'd0);
    step();
    jump_flush = 1'b0;
    check("miss_count0", 32'(q_count), 32'd0);
    check("miss_addr_a", ic_addr, 32'h80000004);
    step();
    step();
    step();
    check("miss_addr_b", ic_addr, 32'h80000004);
    ic_hit = 1'b1;
    #1;
    check("miss_hit_valid", 32'(out_valid), 32'd0);
    step();
    check("miss_redir_addr", ic_addr, 32'h80001000);
    check("miss_redir_count", 32'(q_count), 32'd0);
    step();
    check("miss_head_pc", out_pc, 32'h80001000);
    check("miss_head_count", 32'(q_count), 32'd1);

    // Simultaneous jump and CSR flush: CSR target wins.
    do_reset();
    step();
    step();
    step();
    check("dual_count3", 32'(q_count), 32'd3);
    jump_flush = 1'b1; jump_dnpc = 32'h00000100;
    cs_flush   = 1'b1; cs_dnpc   = 32'h00000200;
    #1;
    check("dual_flush_valid", 32'(out_valid), 32'd0);
    step();
    jump_flush = 1'b0;
    cs_flush   = 1'b0;
    check("dual_empty", 32'(q_count), 32'd0);
    check("dual_addr", ic_addr, 32'h00000200);
    step();
    check("dual_head", out_pc, 32'h00000200);

    // ECALL stalls fetch until a CSR flush.
    mode = 2;
    out_ready = 1'b1;
    do_reset();
    emitted = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) begin
        check("sys_emit_pc", out_pc, 32'h80000000 + 32'(4 * emitted));
        emitted++;
      end
    end
    check("sys_emitted", 32'(emitted), 32'd2);
    check("sys_addr", ic_addr, 32'h80000004);
    cs_flush = 1'b1;
    cs_dnpc  = 32'h80000100;
    step();
    cs_flush = 1'b0;
    check("sys_resume_addr", ic_addr, 32'h80000100);
    step();
    check("sys_resume_valid", 32'(out_valid), 32'd1);
    check("sys_resume_pc", out_pc, 32'h80000100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Parametrised instruction-fetch front end that decouples I-cache lookup from decode through a DEPTH-entry fetch queue.
- Static branch prediction is selectable, and redirect handling is miss-safe.
- Sits between the I-cache (combinational hit/inst for the presented address) and the decode stage.
- Accepts redirects from the jump unit and the CSR/exception unit.

Parameters:
- RESET_PC, 32'h80000000, fetch address after reset.
- DEPTH, 4, fetch-queue entries; power of 2, >=2.
- BP_EN, 1, 1 = backward branches predicted taken and JAL followed; 0 = always pc+4.
- STALL_ON_SYS, 1, 1 = stop fetching after an opcode[6:2]==5'b11100 instruction until a flush.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ic_addr  output  32  fetch address presented to the I-cache (= fetch_pc)
- ic_hit  input  1  cache holds ic_addr this cycle; ic_inst valid
- ic_inst  input  32  instruction word at ic_addr
- jump_flush  input  1  branch-mispredict redirect
- jump_dnpc  input  32  target for jump_flush
- cs_flush  input  1  CSR/exception redirect; priority over jump_flush
- cs_dnpc  input  32  target for cs_flush
- out_ready  input  1  decode accepts
- out_valid  output  1  queue head valid
- out_pc  output  32  head pc
- out_inst  output  32  head instruction
- out_pred_taken  output  1  fetch followed a non-sequential prediction for this instruction
- q_count  output  $clog2(DEPTH+1)  occupancy (debug/perf)

Behaviour:
- Reset: fetch_pc=RESET_PC; queue empty; q_count=0; out_valid=0; redirect_pending=0; sys_stall=0. out_pc, out_inst and out_pred_taken are don't-care while out_valid=0.
- Redirect input: flush = jump_flush|cs_flush; dnpc = cs_flush ? cs_dnpc : jump_dnpc.
- out_valid = ~empty & ~flush, combinational. The head is visible the cycle after enqueue; there is no fall-through from cache to output.
- Prediction, computed from ic_inst:
  - incr = B-type with inst[31]=1 ? imm_b : JAL ? imm_j : 4.
  - With BP_EN=0, incr is always 4.
  - pred_taken = (incr != 4).
  - next = fetch_pc + incr, modulo 2^32.
- enq = ic_hit & ~flush & ~redirect_pending & ~sys_stall & (~full | deq).
- deq = out_valid & out_ready.
- Enqueue writes {fetch_pc, ic_inst, pred_taken} at the tail. Same-cycle enq+deq on a full queue is legal, and q_count is unchanged.
- fetch_pc moves only in a cycle with ic_hit=1. The cache may be mid-refill for the current address and must not see it change.
  - Priority 1: flush & ic_hit -> fetch_pc=dnpc.
  - Priority 2: redirect_pending & ic_hit -> fetch_pc=dnpc_r, clear pending.
  - Priority 3: enq -> fetch_pc=next.
  - Otherwise hold.
- flush & ~ic_hit: redirect_pending=1, dnpc_r=dnpc. A later flush while pending overwrites dnpc_r (last writer wins).
- Flush empties the queue at the next edge: pointers reset, count=0. Any same-cycle enq or deq is discarded.
- Flush also clears sys_stall.
- STALL_ON_SYS=1:
  - Enqueueing a SYS instruction sets sys_stall.
  - fetch_pc then holds at the SYS pc, and no further enqueues occur until a flush.
  - Queued entries still drain normally.
- Pointers wrap modulo DEPTH. Full: count==DEPTH. Empty: count==0.
- Reset asserted mid-miss or with a redirect pending: all state returns to reset values. Outstanding cache activity is the cache's concern.

Test Plan:
- Reset, cache always hits with NOPs (0x00000013), out_ready=1 -> pcs 0x80000000, 0x80000004, ... one per cycle from cycle 2; out_pred_taken=0.
- out_ready=0 for 10 cycles, always hit -> q_count saturates at 4 and ic_addr holds at 0x80000010. Releasing out_ready drains 0x80000000..0x8000000C in order with no gaps or duplicates.
- BEQ with imm=-8 at 0x80000008, BP_EN=1 -> next enqueued pc 0x80000000, that beq has out_pred_taken=1. Same stimulus with BP_EN=0 -> 0x8000000C, pred_taken=0.
- Miss on 0x80000004 (ic_hit=0 for 5 cycles), pulse jump_flush dnpc=0x80001000 at miss cycle 2 -> ic_addr stays 0x80000004 until the hit, then becomes 0x80001000. Nothing from 0x80000004 is ever enqueued, and out_valid=0 in the flush cycle.
- jump_flush and cs_flush together (0x100 vs 0x200) with the queue holding 3 entries -> queue empty next cycle, fetch resumes at 0x200.
- ECALL (0x00000073) at 0x80000004, STALL_ON_SYS=1 -> exactly 2 entries emitted, ic_addr stuck at 0x80000004. cs_flush to 0x80000100 resumes fetch there.
